chunk_burst_walker: RTL and testbench

- Receiving end of the DMA pipeline's mofs stream. One handshake carries one (which, mofs, id, islast_id) beat from the chunk-head stage.
- Each beat is linearized into a global element address using per-config strides. The block then walks the config's rows and emits one DRAM burst command per CSIZE-aligned burst touched, with in-burst begin/end masks.
- Sits between the chunk-head stage and the DRAM request arbiter.

---
 rtl/chunk_burst_walker_pkg.sv | 24 ++
 rtl/chunk_burst_walker_if.sv | 43 ++++
 rtl/chunk_burst_walker_mofs_linearize.sv | 16 +
 rtl/chunk_burst_walker.sv | 131 +++++++++++++
 tb/tb_chunk_burst_walker.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chunk_burst_walker_pkg.sv
// rtl/chunk_burst_walker_pkg.sv - shared parameters and types for the chunk burst walker
package chunk_burst_walker_pkg;
  localparam int WBW     = 16;
  localparam int DIM     = 4;
  localparam int N_ICFG  = 4;
  localparam int ABW     = 24;
  localparam int CSIZE   = 32;
  localparam int ICFG_BW = $clog2(N_ICFG + 1);
  localparam int CS_BW   = $clog2(CSIZE);
  localparam int BBW     = ABW - CS_BW;
  localparam int IDX_BW  = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  typedef logic [ABW-1:0] addr_t;

  function automatic logic [BBW-1:0] burst_of(input addr_t a);
    return a[ABW-1:CS_BW];
  endfunction
endpackage

// File: rtl/chunk_burst_walker_if.sv
// rtl/chunk_burst_walker_if.sv - mofs beat input, per-config tables and burst command output
interface chunk_burst_walker_if;
  import chunk_burst_walker_pkg::*;

  logic                                 i_mofs_rdy;
  logic                                 i_mofs_ack;
  logic                                 i_which;
  logic [DIM-1:0][WBW-1:0]              i_mofs;
  logic [ICFG_BW-1:0]                   i_id;
  logic                                 i_islast_id;
  logic [N_ICFG-1:0][ABW-1:0]           i_mbase;
  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0]  i_mstride;
  logic [N_ICFG-1:0][WBW-1:0]           i_row_len;
  logic [N_ICFG-1:0][WBW-1:0]           i_row_cnt;
  logic [N_ICFG-1:0][ABW-1:0]           i_row_stride;
  logic                                 o_cmd_rdy;
  logic                                 o_cmd_ack;
  logic                                 o_cmd_which;
  logic [ICFG_BW-1:0]                   o_cmd_id;
  logic [ABW-1:0]                       o_cmd_addr;
  logic [CS_BW-1:0]                     o_cmd_beg;
  logic [CS_BW-1:0]                     o_cmd_end;
  logic                                 o_cmd_lastrow;
  logic                                 o_cmd_islast;

  modport master (
    output i_mofs_rdy, i_which, i_mofs, i_id, i_islast_id,
    output i_mbase, i_mstride, i_row_len, i_row_cnt, i_row_stride,
    input  i_mofs_ack,
    input  o_cmd_rdy, o_cmd_which, o_cmd_id, o_cmd_addr, o_cmd_beg, o_cmd_end,
    input  o_cmd_lastrow, o_cmd_islast,
    output o_cmd_ack
  );

  modport slave (
    input  i_mofs_rdy, i_which, i_mofs, i_id, i_islast_id,
    input  i_mbase, i_mstride, i_row_len, i_row_cnt, i_row_stride,
    output i_mofs_ack,
    output o_cmd_rdy, o_cmd_which, o_cmd_id, o_cmd_addr, o_cmd_beg, o_cmd_end,
    output o_cmd_lastrow, o_cmd_islast,
    input  o_cmd_ack
  );
endinterface

// File: rtl/chunk_burst_walker_mofs_linearize.sv
// rtl/chunk_burst_walker_mofs_linearize.sv - base plus sum of mofs times stride, wrapping at ABW bits
module mofs_linearize
  import chunk_burst_walker_pkg::*;
(
  input  logic [DIM-1:0][WBW-1:0] mofs,
  input  logic [DIM-1:0][ABW-1:0] stride,
  input  logic [ABW-1:0]          base,
  output logic [ABW-1:0]          addr
);
  always_comb begin
    addr = base;
    for (int d = 0; d < DIM; d++) begin
      addr = addr + ABW'(mofs[d]) * stride[d];
    end
  end
endmodule

// File: rtl/chunk_burst_walker.sv
// rtl/chunk_burst_walker.sv - linearizes a mofs beat and walks its rows as burst-aligned commands
module chunk_burst_walker
  import chunk_burst_walker_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  chunk_burst_walker_if.slave  bus
);
  localparam logic [ICFG_BW-1:0] NCFG = ICFG_BW'(N_ICFG);

  state_t                  state, state_nx;
  logic                    which_q, islast_q;
  logic [DIM-1:0][WBW-1:0] mofs_q;
  logic [ICFG_BW-1:0]      id_q;
  addr_t                   row_start;
  logic [WBW-1:0]          row_idx;
  logic [BBW-1:0]          cur_blk;

  addr_t                   cfg_base, cfg_rstride, lin_addr, row_end, next_row_start;
  logic [DIM-1:0][ABW-1:0] cfg_stride;
  logic [WBW-1:0]          cfg_len, cfg_cnt;
  logic                    at_first, at_last, last_row, empty_beat;

  // An out-of-range id selects an all-zero config, so the beat emits nothing.
  always_comb begin
    cfg_base    = '0;
    cfg_rstride = '0;
    cfg_stride  = '0;
    cfg_len     = '0;
    cfg_cnt     = '0;
    if (id_q < NCFG) begin
      cfg_base    = bus.i_mbase[id_q[IDX_BW-1:0]];
      cfg_rstride = bus.i_row_stride[id_q[IDX_BW-1:0]];
      cfg_stride  = bus.i_mstride[id_q[IDX_BW-1:0]];
      cfg_len     = bus.i_row_len[id_q[IDX_BW-1:0]];
      cfg_cnt     = bus.i_row_cnt[id_q[IDX_BW-1:0]];
    end
  end

  mofs_linearize u_lin (
    .mofs   (mofs_q),
    .stride (cfg_stride),
    .base   (cfg_base),
    .addr   (lin_addr)
  );

  assign row_end        = row_start + addr_t'(cfg_len) - addr_t'(1);
  assign next_row_start = row_start + cfg_rstride;
  assign at_first       = (cur_blk == burst_of(row_start));
  assign at_last        = (cur_blk == burst_of(row_end));
  assign last_row       = (row_idx == cfg_cnt - WBW'(1));
  assign empty_beat     = (cfg_len == '0) || (cfg_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_mofs_rdy) state_nx = CALC;
      CALC:    state_nx = empty_beat ? IDLE : EMIT;
      EMIT:    if (bus.o_cmd_ack && at_last && last_row) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.i_mofs_ack    = 1'b0;
    bus.o_cmd_rdy     = 1'b0;
    bus.o_cmd_which   = 1'b0;
    bus.o_cmd_id      = '0;
    bus.o_cmd_addr    = '0;
    bus.o_cmd_beg     = '0;
    bus.o_cmd_end     = '0;
    bus.o_cmd_lastrow = 1'b0;
    bus.o_cmd_islast  = 1'b0;
    case (state)
      IDLE: bus.i_mofs_ack = bus.i_mofs_rdy;
      EMIT: begin
        bus.o_cmd_rdy     = 1'b1;
        bus.o_cmd_which   = which_q;
        bus.o_cmd_id      = id_q;
        bus.o_cmd_addr    = {cur_blk, {CS_BW{1'b0}}};
        bus.o_cmd_beg     = at_first ? row_start[CS_BW-1:0] : '0;
        bus.o_cmd_end     = at_last ? row_end[CS_BW-1:0] : '1;
        bus.o_cmd_lastrow = at_last && last_row;
        bus.o_cmd_islast  = at_last && last_row && islast_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      which_q   <= 1'b0;
      islast_q  <= 1'b0;
      mofs_q    <= '0;
      id_q      <= '0;
      row_start <= '0;
      row_idx   <= '0;
      cur_blk   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_mofs_rdy) begin
          which_q  <= bus.i_which;
          islast_q <= bus.i_islast_id;
          mofs_q   <= bus.i_mofs;
          id_q     <= bus.i_id;
        end
        CALC: begin
          row_start <= lin_addr;
          row_idx   <= '0;
          cur_blk   <= burst_of(lin_addr);
        end
        EMIT: if (bus.o_cmd_ack) begin
          // Row done: jump to the next row's first burst; otherwise step one burst.
          if (at_last) begin
            row_start <= next_row_start;
            row_idx   <= row_idx + WBW'(1);
            cur_blk   <= burst_of(next_row_start);
          end else begin
            cur_blk <= cur_blk + BBW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunk_burst_walker.sv
// tb/tb_chunk_burst_walker.sv - table vectors, corner sequences and randomized beats against a model
module tb_chunk_burst_walker;
  import chunk_burst_walker_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  chunk_burst_walker_if bus ();
  chunk_burst_walker dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  typedef struct {
    logic [ABW-1:0]          mbase;
    logic [DIM-1:0][ABW-1:0] st;
    logic [DIM-1:0][WBW-1:0] mo;
    logic [WBW-1:0]          len;
    logic [WBW-1:0]          cnt;
    logic [ABW-1:0]          rs;
    logic [ICFG_BW-1:0]      id;
    logic                    islast;
    int                      n;
    logic [2:0][ABW-1:0]     ea;
    logic [2:0][CS_BW-1:0]   eb;
    logic [2:0][CS_BW-1:0]   ee;
  } vec_t;

  typedef struct {
    logic [ABW-1:0]   addr;
    logic [CS_BW-1:0] beg;
    logic [CS_BW-1:0] fin;
    logic             lastrow;
  } cmd_t;

  cmd_t exp_q[$];
  vec_t tbl[5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [ABW-1:0] mbase, input logic [DIM-1:0][ABW-1:0] st,
                              input logic [DIM-1:0][WBW-1:0] mo, input int len, input int cnt,
                              input logic [ABW-1:0] rs, input int id, input bit islast, input int n,
                              input logic [2:0][ABW-1:0] ea, input logic [2:0][CS_BW-1:0] eb,
                              input logic [2:0][CS_BW-1:0] ee);
    vec_t v;
    v.mbase = mbase; v.st = st; v.mo = mo; v.len = WBW'(len); v.cnt = WBW'(cnt);
    v.rs = rs; v.id = ICFG_BW'(id); v.islast = islast; v.n = n;
    v.ea = ea; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  // Reference: enumerate every burst each row touches using plain integer arithmetic.
  task automatic model(input vec_t v);
    longint mask = (64'd1 << ABW) - 1;
    longint bmask = (64'd1 << (ABW - CS_BW)) - 1;
    longint base, s, e, nb;
    cmd_t c;
    if (v.len == 0 || v.cnt == 0) return;
    base = longint'(v.mbase);
    for (int d = 0; d < DIM; d++) base += longint'(v.mo[d]) * longint'(v.st[d]);
    base &= mask;
    for (int r = 0; r < int'(v.cnt); r++) begin
      s = (base + longint'(r) * longint'(v.rs)) & mask;
      e = (s + longint'(v.len) - 1) & mask;
      nb = (((e / CSIZE) - (s / CSIZE)) & bmask) + 1;
      for (longint k = 0; k < nb; k++) begin
        c.addr    = ABW'((((s / CSIZE) + k) & bmask) * CSIZE);
        c.beg     = (k == 0) ? CS_BW'(s % CSIZE) : '0;
        c.fin     = (k == nb - 1) ? CS_BW'(e % CSIZE) : CS_BW'(CSIZE - 1);
        c.lastrow = (k == nb - 1) && (r == int'(v.cnt) - 1);
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic load_cfg(input vec_t v);
    bus.i_mbase[v.id[IDX_BW-1:0]]      = v.mbase;
    bus.i_mstride[v.id[IDX_BW-1:0]]    = v.st;
    bus.i_row_len[v.id[IDX_BW-1:0]]    = v.len;
    bus.i_row_cnt[v.id[IDX_BW-1:0]]    = v.cnt;
    bus.i_row_stride[v.id[IDX_BW-1:0]] = v.rs;
    bus.i_mofs = v.mo;
    bus.i_id = v.id;
    bus.i_islast_id = v.islast;
  endtask

  // mode 0: always ack, 1: random ack, 2: hold ack low for 5 cycles after the first command
  task automatic do_beat(input vec_t v, input logic which, input int mode, input bit use_tbl);
    bit acked, done, seen_rdy, hold_v;
    int lat, nexp;
    logic [39:0] held, snap;
    cmd_t c;
    exp_q.delete();
    if (use_tbl) begin
      for (int k = 0; k < v.n; k++) begin
        c.addr = v.ea[k]; c.beg = v.eb[k]; c.fin = v.ee[k]; c.lastrow = (k == v.n - 1);
        exp_q.push_back(c);
      end
    end else model(v);
    nexp = exp_q.size();
    load_cfg(v);
    bus.i_which = which;
    bus.o_cmd_ack = 1'b0;
    bus.i_mofs_rdy = 1'b1;
    acked = 0;
    for (int t = 0; t < 20 && !acked; t++) begin
      @(negedge i_clk);
      if (bus.i_mofs_ack) acked = 1;
      @(posedge i_clk); #1;
    end
    chk("mofs_ack_seen", 64'(acked), 64'd1);
    if (!acked) begin bus.i_mofs_rdy = 1'b0; return; end
    if (nexp == 0) bus.i_mofs_rdy = 1'b0;
    lat = 1; done = (nexp == 0); seen_rdy = 0; hold_v = 0; held = '0;
    for (int t = 0; t < 300 && !done; t++) begin
      case (mode)
        0: bus.o_cmd_ack = 1'b1;
        1: bus.o_cmd_ack = 1'($urandom_range(0, 1));
        default: bus.o_cmd_ack = !(t >= 2 && t <= 6);
      endcase
      @(negedge i_clk);
      chk("mofs_ack_busy", 64'(bus.i_mofs_ack), 64'd0);
      if (bus.o_cmd_rdy) begin
        snap = {bus.o_cmd_which, bus.o_cmd_id, bus.o_cmd_addr, bus.o_cmd_beg, bus.o_cmd_end,
                bus.o_cmd_lastrow, bus.o_cmd_islast};
        if (!seen_rdy) begin seen_rdy = 1; chk("first_rdy_latency", 64'(lat), 64'd2); end
        if (hold_v) chk("cmd_stable", 64'(snap), 64'(held));
        if (bus.o_cmd_ack) begin
          hold_v = 0;
          if (exp_q.size() == 0) begin
            chk("extra_cmd", 64'd1, 64'd0);
            done = 1;
          end else begin
            c = exp_q.pop_front();
            chk("cmd_addr", 64'(bus.o_cmd_addr), 64'(c.addr));
            chk("cmd_beg", 64'(bus.o_cmd_beg), 64'(c.beg));
            chk("cmd_end", 64'(bus.o_cmd_end), 64'(c.fin));
            chk("cmd_lastrow", 64'(bus.o_cmd_lastrow), 64'(c.lastrow));
            chk("cmd_islast", 64'(bus.o_cmd_islast), 64'(c.lastrow & v.islast));
            chk("cmd_which", 64'(bus.o_cmd_which), 64'(which));
            chk("cmd_id", 64'(bus.o_cmd_id), 64'(v.id));
            if (bus.o_cmd_lastrow) done = 1;
          end
        end else begin
          hold_v = 1;
          held = snap;
        end
      end
      @(posedge i_clk); #1;
      lat++;
    end
    bus.i_mofs_rdy = 1'b0;
    bus.o_cmd_ack = 1'b0;
    chk("beat_done", 64'(done), 64'd1);
    chk("cmds_left", 64'(exp_q.size()), 64'd0);
    if (nexp == 0) begin
      for (int t = 0; t < 3; t++) begin
        @(negedge i_clk);
        chk("no_cmd", 64'(bus.o_cmd_rdy), 64'd0);
      end
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    vec_t v;
    int gap;
    bit got;
    tbl[0] = mk(24'h100, {24'd0, 24'd0, 24'd64, 24'd1}, {16'd0, 16'd0, 16'd1, 16'd3}, 10, 1, 24'h0, 0, 1,
                1, {24'h0, 24'h0, 24'h140}, {5'd0, 5'd0, 5'd3}, {5'd0, 5'd0, 5'd12});
    tbl[1] = mk(24'h15E, '0, '0, 10, 1, 24'h0, 1, 1,
                2, {24'h0, 24'h160, 24'h140}, {5'd0, 5'd0, 5'd30}, {5'd0, 5'd7, 5'd31});
    tbl[2] = mk(24'h100, '0, '0, 32, 3, 24'h40, 2, 0,
                3, {24'h180, 24'h140, 24'h100}, '0, {5'd31, 5'd31, 5'd31});
    tbl[3] = mk(24'h200, '0, '0, 0, 2, 24'h0, 3, 1, 0, '0, '0, '0);
    tbl[4] = mk(24'hFFFFF0, '0, '0, 32, 1, 24'h0, 0, 1,
                2, {24'h0, 24'h000000, 24'hFFFFE0}, {5'd0, 5'd0, 5'd16}, {5'd0, 5'd15, 5'd31});

    i_rst = 1'b1;
    bus.i_mofs_rdy = 0; bus.i_which = 0; bus.i_mofs = '0; bus.i_id = '0; bus.i_islast_id = 0;
    bus.i_mbase = '0; bus.i_mstride = '0; bus.i_row_len = '0; bus.i_row_cnt = '0;
    bus.i_row_stride = '0; bus.o_cmd_ack = 0;
    repeat (2) @(negedge i_clk);
    chk("rst_cmd_rdy", 64'(bus.o_cmd_rdy), 64'd0);
    chk("rst_cmd_addr", 64'(bus.o_cmd_addr), 64'd0);
    chk("rst_cmd_lastrow", 64'(bus.o_cmd_lastrow), 64'd0);
    chk("rst_mofs_ack", 64'(bus.i_mofs_ack), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < 5; i++) do_beat(tbl[i], 1'(i), 0, 1);

    // Backpressure in the middle of the multi-row beat
    do_beat(tbl[2], 1'b1, 2, 1);

    // Zero-length beats: the next beat is accepted two cycles after the first
    load_cfg(tbl[3]);
    bus.i_mofs_rdy = 1'b1;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if (bus.i_mofs_ack) got = 1;
      @(posedge i_clk); #1;
    end
    chk("zl_first_ack", 64'(got), 64'd1);
    gap = 0; got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      gap++;
      @(negedge i_clk);
      if (bus.i_mofs_ack) got = 1;
      @(posedge i_clk); #1;
    end
    bus.i_mofs_rdy = 1'b0;
    chk("zl_next_ack_gap", 64'(gap), 64'd2);
    repeat (3) @(posedge i_clk);
    #1;

    // Reset while the second command of the multi-row beat is pending
    load_cfg(tbl[2]);
    bus.i_mofs_rdy = 1'b1;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if (bus.i_mofs_ack) got = 1;
      @(posedge i_clk); #1;
    end
    bus.i_mofs_rdy = 1'b0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge i_clk);
      if (bus.o_cmd_rdy) got = 1;
      else begin @(posedge i_clk); #1; end
    end
    chk("rst_seq_cmd0", 64'(got), 64'd1);
    bus.o_cmd_ack = 1'b1;
    @(posedge i_clk); #1;
    bus.o_cmd_ack = 1'b0;
    chk("rst_seq_cmd1_addr", 64'(bus.o_cmd_addr), 64'h140);
    #1 i_rst = 1'b1;
    #1;
    chk("rst_mid_rdy", 64'(bus.o_cmd_rdy), 64'd0);
    chk("rst_mid_addr", 64'(bus.o_cmd_addr), 64'd0);
    chk("rst_mid_end", 64'(bus.o_cmd_end), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    bus.o_cmd_ack = 1'b1;
    got = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge i_clk);
      if (bus.o_cmd_rdy) got = 1;
    end
    chk("rst_no_residual", 64'(got), 64'd0);
    @(posedge i_clk); #1;
    bus.o_cmd_ack = 1'b0;
    do_beat(tbl[0], 1'b0, 0, 1);

    // Randomized beats against the reference model
    for (int i = 0; i < 40; i++) begin
      v.mbase = ABW'($urandom);
      for (int d = 0; d < DIM; d++) begin
        v.st[d] = (i % 3 == 0) ? ABW'($urandom_range(0, 300)) : ABW'($urandom);
        v.mo[d] = WBW'($urandom);
      end
      v.len = WBW'($urandom_range(0, 80));
      v.cnt = WBW'($urandom_range(0, 4));
      v.rs = ABW'($urandom);
      v.id = ICFG_BW'($urandom_range(0, N_ICFG - 1));
      v.islast = 1'($urandom_range(0, 1));
      v.n = 0; v.ea = '0; v.eb = '0; v.ee = '0;
      do_beat(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
